// File: rtl/reqack_pkg.sv
// reqack_pkg: FSM state encoding and the latency helper shared by reqack_responder.
package reqack_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } reqack_state_e;

  // A programmed latency of zero is served as one cycle, so rise-to-ack is never below two edges.
  function automatic logic [31:0] eff_lat_f(input logic [31:0] lat);
    return (lat == '0) ? 32'd1 : lat;
  endfunction

endpackage

// File: rtl/reqack_lat_fifo.sv
// reqack_lat_fifo: DEPTH x WIDTH synchronous FIFO holding effective latencies of queued requests.
// Head entry is visible combinationally on data_o; count_o is registered.
module reqack_lat_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en, rd_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal when a pop frees the slot at the same edge.
  assign wr_en = push_i && (!full_o || pop_i);
  assign rd_en = pop_i && !empty_o;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_en ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (wr_en && !rd_en) begin
      count_d = count_q + CNT_W'(1);
    end else if (!wr_en && rd_en) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while the slot is not occupied.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/reqack_responder.sv
// reqack_responder: responder side of a req/ack handshake. Each rising edge of req is
// queued with its latency and answered by exactly one single-cycle ack pulse.
// Optional macro REQACK_RESP_ASSERT_EN embeds concurrent protocol assertions.
module reqack_responder
  import reqack_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LAT_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req,
  input  logic [LAT_W-1:0]           lat,
  output logic                       ack,
  output logic [$clog2(DEPTH+1)-1:0] pending,
  output logic                       busy,
  output logic                       overflow
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  reqack_state_e    state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic             req_q;
  logic             ovf_q, ovf_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             rise, push, pop;
  logic             fifo_full, fifo_empty;
  logic [LAT_W-1:0] push_lat, head_lat;
  logic [CNT_W-1:0] fifo_count;

  assign rise     = req && !req_q;
  assign push_lat = LAT_W'(eff_lat_f(32'(lat)));
  // A rise into a full FIFO survives only if the FSM pops at the same edge.
  assign push     = rise && (!fifo_full || pop);
  assign ovf_d    = ovf_q || (rise && fifo_full && !pop);

  reqack_lat_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (LAT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (push_lat),
    .data_o  (head_lat),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Rise detector history and sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      req_q <= req;
      ovf_q <= ovf_d;
    end
  end

  // FSM state and latency down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: pop from IDLE or straight out of ACK so back-to-back requests see no idle bubble.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cnt_d   = head_lat - LAT_W'(1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end
      ACK: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cnt_d   = head_lat - LAT_W'(1);
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so ack/busy are registered alongside state_q.
  always_comb begin
    ack_d  = (state_d == ACK);
    busy_d = (state_d != IDLE);
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      ack_q  <= ack_d;
      busy_q <= busy_d;
    end
  end

  assign ack      = ack_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;
  assign pending  = fifo_count;

`ifdef REQACK_RESP_ASSERT_EN
  a_rise_gets_ack: assert property (@(posedge clk) disable iff (!rst_n)
    (rise && !ovf_d) |-> ##[1:$] ack);
  a_ack_one_cycle: assert property (@(posedge clk) disable iff (!rst_n)
    ack |=> !ack);
  a_pending_bound: assert property (@(posedge clk) disable iff (!rst_n)
    pending <= CNT_W'(DEPTH));
  a_ack_after_wait: assert property (@(posedge clk) disable iff (!rst_n)
    ack |-> ($past(state_q) == WAIT));
`else
  // No embedded assertions in this build.
`endif

endmodule

// File: tb/tb_reqack_responder.sv
// tb_reqack_responder: self-checking bench. The reference model schedules every accepted
// request directly: pop edge = max(push+1, previous ack edge+1), ack edge = pop + eff_lat.
module tb_reqack_responder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LAT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req = 1'b0;
  logic [LAT_W-1:0] lat = '0;
  logic             ack, busy, overflow;
  logic [2:0]       pending;

  int n_checks = 0;
  int n_errors = 0;
  int ecount = 0;

  int push_e[$];
  int pop_e[$];
  int ack_e[$];
  bit m_prev = 1'b0;
  bit m_ovf = 1'b0;

  reqack_responder #(
    .DEPTH (DEPTH),
    .LAT_W (LAT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .lat      (lat),
    .ack      (ack),
    .pending  (pending),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  function automatic void model_clear();
    push_e.delete();
    pop_e.delete();
    ack_e.delete();
    m_prev = 1'b0;
    m_ovf  = 1'b0;
  endfunction

  function automatic void model_edge();
    bit rise;
    int occ;
    bit popnow;
    int eff;
    int p;
    if (!rst_n) begin
      model_clear();
      return;
    end
    rise   = req && !m_prev;
    m_prev = req;
    if (!rise) return;
    eff    = (lat == 0) ? 1 : int'(lat);
    occ    = 0;
    popnow = 1'b0;
    foreach (push_e[k]) begin
      if (push_e[k] < ecount && pop_e[k] >= ecount) occ++;
      if (pop_e[k] == ecount) popnow = 1'b1;
    end
    if (occ < int'(DEPTH) || popnow) begin
      p = ecount + 1;
      if (ack_e.size() > 0 && ack_e[ack_e.size()-1] + 1 > p) p = ack_e[ack_e.size()-1] + 1;
      push_e.push_back(ecount);
      pop_e.push_back(p);
      ack_e.push_back(p + eff);
    end else begin
      m_ovf = 1'b1;
    end
  endfunction

  function automatic bit m_ack();
    foreach (ack_e[k]) if (ack_e[k] == ecount) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_busy();
    foreach (pop_e[k]) if (pop_e[k] <= ecount && ecount <= ack_e[k]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_pending();
    int c = 0;
    foreach (push_e[k]) if (push_e[k] <= ecount && ecount < pop_e[k]) c++;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    ecount++;
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req = ~req;
      tick();
      n_checks++;
      if ({ack, busy, overflow, pending} !== 6'b0) begin
        n_errors++;
        $display("FAIL reset_outputs edge %0d: got ack=%b busy=%b ovf=%b pend=%0d, expected all 0",
                 ecount, ack, busy, overflow, pending);
      end
    end
    req   = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_single(input logic [LAT_W-1:0] l, input int exp_delay, input string name);
    int t0;
    int ack_edge = -1;
    int n_ack = 0;
    req = 1'b1;
    lat = l;
    tick();
    t0 = ecount;
    n_checks++;
    if (pending !== 3'd1) begin
      n_errors++;
      $display("FAIL %s_pending_after_rise: got %0d expected 1", name, pending);
    end
    req = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (ack === 1'b1) begin
        ack_edge = ecount;
        n_ack++;
      end
      n_checks++;
      if (ack !== m_ack()) begin
        n_errors++;
        $display("FAIL %s_ack edge %0d: got %b expected %b", name, ecount, ack, m_ack());
      end
      n_checks++;
      if (busy !== m_busy()) begin
        n_errors++;
        $display("FAIL %s_busy edge %0d: got %b expected %b", name, ecount, busy, m_busy());
      end
    end
    n_checks++;
    if (n_ack != 1 || ack_edge != t0 + exp_delay) begin
      n_errors++;
      $display("FAIL %s_ack_timing: got %0d pulses at +%0d, expected 1 pulse at +%0d",
               name, n_ack, ack_edge - t0, exp_delay);
    end
  endtask

  task automatic test_back_to_back();
    int t0 = 0;
    int max_pend = 0;
    int acks[$];
    for (int i = 0; i < 10; i++) begin
      req = (i % 2 == 0) && (i < 6);
      lat = 4'd1;
      tick();
      if (i == 0) t0 = ecount;
      if (ack === 1'b1) acks.push_back(ecount - t0);
      if (int'(pending) > max_pend) max_pend = int'(pending);
      n_checks++;
      if (ack !== m_ack() || int'(pending) != m_pending()) begin
        n_errors++;
        $display("FAIL b2b_cycle edge %0d: got ack=%b pend=%0d expected ack=%b pend=%0d",
                 ecount, ack, pending, m_ack(), m_pending());
      end
    end
    n_checks++;
    if (acks.size() != 3 || acks[0] != 2 || acks[1] != 4 || acks[2] != 6) begin
      n_errors++;
      $display("FAIL b2b_ack_edges: got %0d pulses %p expected 3 pulses at +2 +4 +6", acks.size(), acks);
    end
    n_checks++;
    if (max_pend > 1) begin
      n_errors++;
      $display("FAIL b2b_max_pending: got %0d expected <=1", max_pend);
    end
  endtask

  task automatic test_overflow();
    int n_ack = 0;
    for (int i = 0; i < 112; i++) begin
      req = (i % 2 == 0) && (i <= 10);
      lat = 4'd15;
      tick();
      if (ack === 1'b1) n_ack++;
      if (i == 10) begin
        n_checks++;
        if (pending !== 3'd4 || overflow !== 1'b1) begin
          n_errors++;
          $display("FAIL ovf_at_drop: got pend=%0d ovf=%b expected pend=4 ovf=1", pending, overflow);
        end
      end
      n_checks++;
      if (ack !== m_ack() || int'(pending) != m_pending() || overflow !== m_ovf) begin
        n_errors++;
        $display("FAIL ovf_cycle edge %0d: got ack=%b pend=%0d ovf=%b expected ack=%b pend=%0d ovf=%b",
                 ecount, ack, pending, overflow, m_ack(), m_pending(), m_ovf);
      end
    end
    n_checks++;
    if (n_ack != 5 || overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf_ack_count: got %0d acks ovf=%b expected 5 acks ovf=1", n_ack, overflow);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) begin
      req = (i % 2 == 0) && (i <= 4);
      lat = 4'd15;
      tick();
    end
    n_checks++;
    if (pending !== 3'd2 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL rstmid_preload: got pend=%0d busy=%b expected pend=2 busy=1", pending, busy);
    end
    rst_n = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if ({ack, busy, overflow, pending} !== 6'b0) begin
      n_errors++;
      $display("FAIL rstmid_async: got ack=%b busy=%b ovf=%b pend=%0d expected all 0",
               ack, busy, overflow, pending);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      n_checks++;
      if (ack !== 1'b0 || busy !== 1'b0 || pending !== 3'd0) begin
        n_errors++;
        $display("FAIL rstmid_quiet edge %0d: got ack=%b busy=%b pend=%0d expected 0 0 0",
                 ecount, ack, busy, pending);
      end
    end
    req = 1'b1;
    lat = 4'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      req = 1'b0;
      n_checks++;
      if (ack !== m_ack() || busy !== m_busy()) begin
        n_errors++;
        $display("FAIL rstmid_restart edge %0d: got ack=%b busy=%b expected ack=%b busy=%b",
                 ecount, ack, busy, m_ack(), m_busy());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if ({ack, busy, overflow, pending} !== 6'b0) begin
          n_errors++;
          $display("FAIL rand_async_reset: got ack=%b busy=%b ovf=%b pend=%0d expected all 0",
                   ack, busy, overflow, pending);
        end
        tick();
        rst_n = 1'b1;
      end
      req = 1'($urandom_range(0, 1));
      lat = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      tick();
      n_checks++;
      if (ack !== m_ack()) begin
        n_errors++;
        $display("FAIL rand_ack edge %0d: got %b expected %b", ecount, ack, m_ack());
      end
      n_checks++;
      if (busy !== m_busy()) begin
        n_errors++;
        $display("FAIL rand_busy edge %0d: got %b expected %b", ecount, busy, m_busy());
      end
      n_checks++;
      if (int'(pending) != m_pending()) begin
        n_errors++;
        $display("FAIL rand_pending edge %0d: got %0d expected %0d", ecount, pending, m_pending());
      end
      n_checks++;
      if (overflow !== m_ovf) begin
        n_errors++;
        $display("FAIL rand_overflow edge %0d: got %b expected %b", ecount, overflow, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single(4'd2, 3, "single");
    test_single(4'd0, 2, "zero_lat");
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
